// File: rtl/frame_sequencer_pkg.sv
// Shared types and widths for the frame sequencer (state enum, ramp/row/counter widths).
// CONTINUOUS_EN (optional macro) adds back-to-back frame chaining in frame_sequencer.
package frame_sequencer_pkg;

    localparam int RAMP_W = 8;
    localparam int ROW_W  = 2;
    localparam int CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_READ,
        ST_DONE
    } state_t;

endpackage

// File: rtl/frame_sequencer_if.sv
// Control/status bundle between a frame host (master) and the frame sequencer (slave).
// CONTINUOUS_EN does not change this bundle; cont is a separate port on the sequencer.
interface frame_sequencer_if;
    import frame_sequencer_pkg::*;

    // Handshake: start is a level request the sequencer samples only while busy=0;
    // busy=1 means any start is ignored. abort is honoured in every busy state.
    logic              start;
    logic              abort;
    logic              expose_finished;
    logic              erase;
    logic              expose_enable;
    logic              convert;
    logic [RAMP_W-1:0] ramp;
    logic              read_en;
    logic [ROW_W-1:0]  read_row;
    logic              busy;
    logic              frame_done;

    modport master (
        output start, abort, expose_finished,
        input  erase, expose_enable, convert, ramp, read_en, read_row, busy, frame_done
    );

    modport slave (
        input  start, abort, expose_finished,
        output erase, expose_enable, convert, ramp, read_en, read_row, busy, frame_done
    );

endinterface

// File: rtl/frame_sequencer_phase_counter.sv
// Loadable down-counter with zero flag; times the ERASE, CONVERT and READ phases.
// Unaffected by CONTINUOUS_EN.
module phase_counter
    import frame_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/frame_sequencer.sv
// Image-sensor frame sequencer: erase, expose, ADC ramp convert, row read, done pulse.
// Define CONTINUOUS_EN to add the cont input, which chains DONE straight into a new ERASE.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int ERASE_CYCLES   = 5,
    parameter int CONVERT_CYCLES = 255,
    parameter int NROWS          = 2
) (
    input  logic clk,
    input  logic reset,
`ifdef CONTINUOUS_EN
    input  logic cont,
`endif
    frame_sequencer_if.slave bus,
    output state_t state_dbg
);

    // Counter loads are "cycles - 1": the phase ends on the cycle the counter reads zero.
    localparam logic [CNT_W-1:0] ERASE_LOAD   = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONVERT_LOAD = CNT_W'(CONVERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LOAD    = CNT_W'(NROWS - 1);

    state_t            state, next_state;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_value;
    logic              cont_req;

    logic              erase_q, expose_q, convert_q, read_en_q, busy_q, done_q;
    logic [RAMP_W-1:0] ramp_q;
    logic [ROW_W-1:0]  row_q;

`ifdef CONTINUOUS_EN
    assign cont_req = cont;
`else
    assign cont_req = 1'b0;
`endif

    phase_counter u_phase_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_value  = '0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    next_state = ST_ERASE;
                    cnt_load   = 1'b1;
                    cnt_value  = ERASE_LOAD;
                end
            end
            ST_ERASE: begin
                if (cnt_zero) next_state = ST_EXPOSE;
                else          cnt_dec    = 1'b1;
            end
            ST_EXPOSE: begin
                if (bus.expose_finished) begin
                    next_state = ST_CONVERT;
                    cnt_load   = 1'b1;
                    cnt_value  = CONVERT_LOAD;
                end
            end
            ST_CONVERT: begin
                if (cnt_zero) begin
                    next_state = ST_READ;
                    cnt_load   = 1'b1;
                    cnt_value  = READ_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_READ: begin
                if (cnt_zero) next_state = ST_DONE;
                else          cnt_dec    = 1'b1;
            end
            ST_DONE: begin
                if (cont_req) begin
                    next_state = ST_ERASE;
                    cnt_load   = 1'b1;
                    cnt_value  = ERASE_LOAD;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        // Abort overrides every busy-state decision, including a chained restart.
        if (state != ST_IDLE && bus.abort) begin
            next_state = ST_IDLE;
            cnt_load   = 1'b1;
            cnt_value  = '0;
        end
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            erase_q   <= 1'b0;
            expose_q  <= 1'b0;
            convert_q <= 1'b0;
            ramp_q    <= '0;
            read_en_q <= 1'b0;
            row_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= next_state;
            erase_q   <= (next_state == ST_ERASE);
            expose_q  <= (next_state == ST_EXPOSE);
            convert_q <= (next_state == ST_CONVERT);
            ramp_q    <= (state == ST_CONVERT && next_state == ST_CONVERT) ? ramp_q + 1'b1 : '0;
            read_en_q <= (next_state == ST_READ);
            row_q     <= (state == ST_READ && next_state == ST_READ) ? row_q + 1'b1 : '0;
            busy_q    <= (next_state != ST_IDLE);
            done_q    <= (next_state == ST_DONE);
        end
    end

    assign bus.erase         = erase_q;
    assign bus.expose_enable = expose_q;
    assign bus.convert       = convert_q;
    assign bus.ramp          = ramp_q;
    assign bus.read_en       = read_en_q;
    assign bus.read_row      = row_q;
    assign bus.busy          = busy_q;
    assign bus.frame_done    = done_q;
    assign state_dbg         = state;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: builds per-edge stimulus and expected-output queues
// from frame timing rules, then replays them. Define CONTINUOUS_EN to include the chaining case.
module tb_frame_sequencer;
    import frame_sequencer_pkg::*;

    localparam int E = 5;
    localparam int C = 255;
    localparam int N = 2;

    typedef struct packed {
        logic rst;
        logic start;
        logic abort;
        logic ef;
        logic cont;
    } stim_t;

    logic   clk;
    logic   reset;
    state_t state_dbg;
`ifdef CONTINUOUS_EN
    logic   cont;
`endif

    frame_sequencer_if bus ();

    frame_sequencer #(
        .ERASE_CYCLES   (E),
        .CONVERT_CYCLES (C),
        .NROWS          (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef CONTINUOUS_EN
        .cont      (cont),
`endif
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    stim_t       stim_q[$];
    logic [15:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [15:0] pack_out(input bit e, input bit x, input bit c,
                                             input logic [7:0] r, input bit re,
                                             input logic [1:0] rr, input bit b, input bit fd);
        return {e, x, c, r, re, rr, b, fd};
    endfunction

    function automatic logic [15:0] idle_out();
        return pack_out(0, 0, 0, 8'd0, 0, 2'd0, 0, 0);
    endfunction

    // Expected outputs j cycles after the edge that launched a frame.
    function automatic logic [15:0] frame_out(input int j, input int exp_len);
        if (j < E)                       return pack_out(1, 0, 0, 8'd0, 0, 2'd0, 1, 0);
        if (j < E + exp_len)             return pack_out(0, 1, 0, 8'd0, 0, 2'd0, 1, 0);
        if (j < E + exp_len + C)         return pack_out(0, 0, 1, 8'(j - E - exp_len), 0, 2'd0, 1, 0);
        if (j < E + exp_len + C + N)     return pack_out(0, 0, 0, 8'd0, 1, 2'(j - E - exp_len - C), 1, 0);
        return pack_out(0, 0, 0, 8'd0, 0, 2'd0, 1, 1);
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst   = 1'b0;
        s.start = 1'($urandom_range(0, 1));
        s.abort = 1'b0;
        s.ef    = 1'($urandom_range(0, 1));
        s.cont  = 1'b0;
        return s;
    endfunction

    // driver tasks: queue up stimulus and the outputs it must produce
    task automatic add_idle(input int n);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s       = rand_stim();
            s.start = 1'b0;
            s.abort = 1'($urandom_range(0, 1));
            stim_q.push_back(s);
            exp_q.push_back(idle_out());
        end
    endtask

    task automatic add_reset(input int n);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s       = rand_stim();
            s.rst   = 1'b1;
            s.abort = 1'($urandom_range(0, 1));
            stim_q.push_back(s);
            exp_q.push_back(idle_out());
        end
    endtask

    // cut_at < 0: frame runs to completion. Otherwise the edge cut_at carries abort or reset.
    task automatic add_frame(input int exp_len, input int cut_at, input bit cut_rst,
                             input bit from_done, input bit hold_start, input bit chain);
        stim_t s;
        int    total;
        total = E + exp_len + C + N + 1;
        for (int j = 0; j < total; j++) begin
            s = rand_stim();
            if (j == 0) begin
                s.start = from_done ? s.start : 1'b1;
                s.cont  = from_done;
            end else if (j - 1 >= E && j - 1 < E + exp_len) begin
                s.ef = (j - 1 == E + exp_len - 1);
            end
            if (j == cut_at) begin
                if (cut_rst) s.rst = 1'b1;
                else         s.abort = 1'b1;
                stim_q.push_back(s);
                exp_q.push_back(idle_out());
                return;
            end
            stim_q.push_back(s);
            exp_q.push_back(frame_out(j, exp_len));
        end
        if (!chain) begin
            s = rand_stim();
            s.abort = 1'($urandom_range(0, 1));
            if (hold_start) s.start = 1'b1;
            stim_q.push_back(s);
            exp_q.push_back(idle_out());
        end
    endtask

    // scoreboard: replay every queued edge and compare the registered outputs after it
    task automatic run_queue();
        stim_t       s;
        logic [15:0] obs;
        logic [15:0] exp_v;
        int          cyc;
        cyc = 0;
        while (stim_q.size() > 0) begin
            s     = stim_q.pop_front();
            exp_v = exp_q.pop_front();
            reset           = s.rst;
            bus.start       = s.start;
            bus.abort       = s.abort;
            bus.expose_finished = s.ef;
`ifdef CONTINUOUS_EN
            cont            = s.cont;
`endif
            @(posedge clk);
            #1;
            obs = {bus.erase, bus.expose_enable, bus.convert, bus.ramp,
                   bus.read_en, bus.read_row, bus.busy, bus.frame_done};
            n_cmp++;
            assert (obs === exp_v) else begin
                n_err++;
                $error("FAIL outputs cycle=%0d observed=%h expected=%h", cyc, obs, exp_v);
            end
            if (s.rst) begin
                n_cmp++;
                assert (state_dbg === ST_IDLE) else begin
                    n_err++;
                    $error("FAIL reset_state cycle=%0d observed=%0d expected=%0d",
                           cyc, state_dbg, ST_IDLE);
                end
            end
            cyc++;
        end
    endtask

    initial begin
        stim_t s;
        int    el;
        int    total;
        int    cut;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.expose_finished = 1'b0;
`ifdef CONTINUOUS_EN
        cont = 1'b0;
`endif

        add_reset(3);
        add_idle(3);

        // directed default frame: exposure ends after 10 cycles
        add_frame(10, -1, 0, 0, 0, 0);

        // start and abort together in IDLE: frame must not start
        s = rand_stim();
        s.start = 1'b1;
        s.abort = 1'b1;
        stim_q.push_back(s);
        exp_q.push_back(idle_out());
        add_idle(2);

        // abort on the cycle ramp reads 100
        add_frame(7, E + 7 + 100 + 1, 0, 0, 0, 0);
        add_idle(2);

        // reset in the middle of EXPOSE, then a clean full frame
        add_frame(20, E + 5, 1, 0, 0, 0);
        add_idle(2);
        add_frame(3, -1, 0, 0, 0, 0);

        // start held across a whole frame: restart only after one IDLE cycle
        add_frame(4, -1, 0, 0, 1, 0);
        add_frame(1, -1, 0, 0, 0, 0);

        // randomized frames with random abort/reset cut points
        for (int k = 0; k < 6; k++) begin
            el    = $urandom_range(1, 30);
            total = E + el + C + N + 1;
            cut   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, total - 1) : -1;
            add_frame(el, cut, 1'($urandom_range(0, 1)), 0, 0, 0);
            add_idle($urandom_range(0, 3));
        end

`ifdef CONTINUOUS_EN
        // chained frames: DONE with cont=1 goes straight to ERASE, busy never drops
        add_frame(5, -1, 0, 0, 0, 1);
        add_frame(8, -1, 0, 1, 0, 0);
        add_idle(2);
`endif

        run_queue();

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
